mac_row_engine: RTL
===================

# mac_row_engine

Parametrised, pipelined multiply-accumulate engine that computes one output neuron (one weight row) of a fully-connected layer: the dot product of an input pixel vector with a selected signed weight row. It reads `LANES` pixels and `LANES` weights per cycle from synchronous memories, and accumulates with selectable wrap/saturate arithmetic. It applies optional ReLU and can sweep all rows back-to-back from a single start. It sits between the pixel/weight SRAMs and the result buffer of the classifier datapath.

## Interface
- `PIXEL_W`, 8: unsigned pixel width.
- `WEIGHT_W`, 16: signed two's-complement weight width.
- `LANES`, 2: pixels/weights per memory word; `N_INPUTS % LANES == 0`.
- `N_INPUTS`, 784: inputs per row; `W = N_INPUTS/LANES` words per row.
- `N_ROWS`, 10: weight rows; `ROW_W = $clog2(N_ROWS)`.
- `ACC_W`, 32: signed accumulator/result width.
- `PADDR_W`, 10 / `WADDR_W`, 12: memory address widths.

Ports:
- `clk`  in  1: clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `start`  in  1: begin computation; sampled only in IDLE.
- `row_select`  in  ROW_W: row to compute in single-row mode.
- `mode_all`  in  1: 1 = compute rows 0..N_ROWS-1 sequentially.
- `sat_en`  in  1: 1 = saturate on overflow, 0 = wrap.
- `relu_en`  in  1: 1 = clamp negative final result to 0.
- `pixel_addr`  out  PADDR_W: pixel word address.
- `pixel_rd`  out  1: pixel read strobe.
- `pixel_data`  in  LANES*PIXEL_W: lane i at bits [i*PIXEL_W +: PIXEL_W]; valid the cycle after the address.
- `weight_addr`  out  WADDR_W: `row*W + k`.
- `weight_rd`  out  1: weight read strobe.
- `weight_data`  in  LANES*WEIGHT_W: same lane packing and 1-cycle latency.
- `busy`  out  1: high from the start edge until the final row_done.
- `row_done`  out  1: one-cycle pulse when a row result is valid.
- `w_result_ena`  out  1: result-buffer write strobe, coincident with row_done.
- `row_result`  out  ACC_W: signed row result, held until the next row completes.
- `row_index`  out  ROW_W: row that produced row_result.
- `overflow`  out  1: per-row sticky overflow flag, valid with row_done and held.
- `all_done`  out  1: one-cycle pulse with the last row_done of a job.

## Operation
- FSM states:
  - IDLE: on `start`, if `mode_all` or `row_select < N_ROWS`, go to RUN. Otherwise ignore `start`.
  - RUN: issue word k = 0..W-1, one per cycle, with both rd strobes high. After k = W-1, go to DRAIN.
  - DRAIN: wait for the pipeline to empty.
  - DONE: pulse outputs for one cycle. In mode_all with more rows remaining, go to RUN for row+1 and clear the accumulator. Otherwise go to IDLE.
- `row_select`, `mode_all`, `sat_en` and `relu_en` are latched on the start edge. Later changes have no effect on the running job.
- Pipeline: address → memory data → product register (LANES signed products, each PIXEL_W+WEIGHT_W+1 bits, summed to a lane sum) → accumulate.
- Accumulate: compute `acc + lanesum` at ACC_W+1 bits. If the result is outside the signed ACC_W range, set overflow (sticky for the row).
  - sat_en=1: clamp to 2^(ACC_W-1)-1 or -2^(ACC_W-1).
  - sat_en=0: keep the low ACC_W bits.
- Final stage: apply ReLU if enabled, then register into `row_result`. ReLU does not clear `overflow`.
- Accumulator and overflow clear at the start of each row.
- `start` while busy is ignored.

## Timing
- Reset values: all outputs 0, FSM in IDLE, accumulator 0.
- Reset mid-operation aborts immediately. No row_done is produced for the aborted row.
- The start edge is E0. Word k is addressed in the cycle after E(k), data arrives after E(k+1), the product registers at E(k+2), and the accumulation completes at E(k+3).
- row_done, w_result_ena, row_index and row_result update at E(W+3). For defaults, that is edge 395.
- In mode_all, row r+1 begins addressing in the cycle after row r's DONE edge, so each row takes W+3 cycles. all_done coincides with row N_ROWS-1's row_done.
- busy deasserts on the edge after the final DONE cycle.
- pixel_rd and weight_rd are high exactly W cycles per row. Addresses are 0 outside RUN.

## Test plan
- Pixels all 1, weights all 1, row 0, single mode → row_result 784, overflow 0, row_done at E395, weight_addr 0..391.
- Pixels (5,2), weights (7,9), row 1 → row_result 20776, weight_addr 392..783, row_index 1.
- Pixels 0xFF, weights 30000 on both lanes:
  - sat_en=0 → overflow 1, row_result 1702632704.
  - sat_en=1 → overflow 1, row_result 0x7FFFFFFF.
- Pixels 1, weights (0xFF00, 0x0000):
  - relu_en=0 → row_result 0xFFFE7800 (-100352).
  - relu_en=1 → row_result 0, overflow 0.
- mode_all, with row r weights = r+1 and pixels 1 → ten row_done pulses, 395 cycles apart. row_result = 784*(r+1) with row_index r. all_done with row 9 only.
- Assert `rst` 200 cycles into a row → all outputs 0 immediately, no row_done. Then:
  - A fresh start produces 784.
  - A second `start` pulse during busy is ignored.
  - `row_select` = 12 in single mode leaves busy at 0.

Source files
------------

// File: rtl/mac_row_engine.sv
// Multiply-accumulate engine that computes the dot product of a pixel vector with one signed
// weight row (or every row back-to-back), streaming LANES pixel/weight pairs per cycle.
module mac_row_engine #(
    parameter int unsigned PIXEL_W  = 8,
    parameter int unsigned WEIGHT_W = 16,
    parameter int unsigned LANES    = 2,
    parameter int unsigned N_INPUTS = 784,
    parameter int unsigned N_ROWS   = 10,
    parameter int unsigned ACC_W    = 32,
    parameter int unsigned PADDR_W  = 10,
    parameter int unsigned WADDR_W  = 12,
    parameter int unsigned ROW_W    = $clog2(N_ROWS)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [ROW_W-1:0]             row_select,
    input  logic                         mode_all,
    input  logic                         sat_en,
    input  logic                         relu_en,
    output logic [PADDR_W-1:0]           pixel_addr,
    output logic                         pixel_rd,
    input  logic [LANES*PIXEL_W-1:0]     pixel_data,
    output logic [WADDR_W-1:0]           weight_addr,
    output logic                         weight_rd,
    input  logic [LANES*WEIGHT_W-1:0]    weight_data,
    output logic                         busy,
    output logic                         row_done,
    output logic                         w_result_ena,
    output logic [ACC_W-1:0]             row_result,
    output logic [ROW_W-1:0]             row_index,
    output logic                         overflow,
    output logic                         all_done
);

    localparam int unsigned WORDS  = N_INPUTS / LANES;
    localparam int unsigned PROD_W = PIXEL_W + WEIGHT_W + 1;
    localparam int unsigned SUM_W  = PROD_W + $clog2(LANES) + 1;

    localparam logic [PADDR_W-1:0] LAST_WORD  = PADDR_W'(WORDS - 1);
    localparam logic [WADDR_W-1:0] ROW_STRIDE = WADDR_W'(WORDS);
    localparam logic [ROW_W-1:0]   LAST_ROW   = ROW_W'(N_ROWS - 1);
    localparam logic [ACC_W-1:0]   ACC_MAX    = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0]   ACC_MIN    = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_t;

    state_t               state_q;
    logic [ROW_W-1:0]     row_q;
    logic                 mode_all_q;
    logic                 sat_q;
    logic                 relu_q;
    logic [WADDR_W-1:0]   base_q;
    logic                 data_valid_q;
    logic                 prod_valid_q;
    logic [PROD_W-1:0]    prod_q [LANES];
    logic [PROD_W-1:0]    prod_d [LANES];
    logic [ACC_W-1:0]     acc_q;
    logic                 ovf_q;

    logic [SUM_W-1:0]     lane_sum;
    logic [ACC_W:0]       acc_sum;
    logic                 acc_ovf;
    logic [ACC_W-1:0]     acc_next;
    logic [ACC_W-1:0]     relu_val;
    logic [WADDR_W-1:0]   start_base;

    // Pixels are unsigned, so zero-extend them; the low PROD_W bits of the product are exact.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            prod_d[l] = PROD_W'(pixel_data[l*PIXEL_W +: PIXEL_W])
                      * PROD_W'($signed(weight_data[l*WEIGHT_W +: WEIGHT_W]));
        end
    end

    always_comb begin
        lane_sum = '0;
        for (int l = 0; l < LANES; l++) begin
            lane_sum = lane_sum + SUM_W'($signed(prod_q[l]));
        end
        acc_sum = {acc_q[ACC_W-1], acc_q} + (ACC_W+1)'($signed(lane_sum));
        acc_ovf = acc_sum[ACC_W] ^ acc_sum[ACC_W-1];
        if (acc_ovf && sat_q) begin
            acc_next = acc_sum[ACC_W] ? ACC_MIN : ACC_MAX;
        end else begin
            acc_next = acc_sum[ACC_W-1:0];
        end
        relu_val = (relu_q && acc_q[ACC_W-1]) ? '0 : acc_q;
    end

    always_comb begin
        start_base = '0;
        if (!mode_all) begin
            start_base = WADDR_W'(row_select) * ROW_STRIDE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            row_q        <= '0;
            mode_all_q   <= 1'b0;
            sat_q        <= 1'b0;
            relu_q       <= 1'b0;
            base_q       <= '0;
            data_valid_q <= 1'b0;
            prod_valid_q <= 1'b0;
            for (int l = 0; l < LANES; l++) begin
                prod_q[l] <= '0;
            end
            acc_q        <= '0;
            ovf_q        <= 1'b0;
            pixel_addr   <= '0;
            pixel_rd     <= 1'b0;
            weight_addr  <= '0;
            weight_rd    <= 1'b0;
            busy         <= 1'b0;
            row_done     <= 1'b0;
            w_result_ena <= 1'b0;
            row_result   <= '0;
            row_index    <= '0;
            overflow     <= 1'b0;
            all_done     <= 1'b0;
        end else begin
            row_done     <= 1'b0;
            w_result_ena <= 1'b0;
            all_done     <= 1'b0;

            // Memory data follows the read strobe by one cycle; products by one more.
            data_valid_q <= pixel_rd;
            prod_valid_q <= data_valid_q;
            if (data_valid_q) begin
                for (int l = 0; l < LANES; l++) begin
                    prod_q[l] <= prod_d[l];
                end
            end
            if (prod_valid_q) begin
                acc_q <= acc_next;
                if (acc_ovf) begin
                    ovf_q <= 1'b1;
                end
            end

            unique case (state_q)
                StIdle: begin
                    if (start && (mode_all || row_select <= LAST_ROW)) begin
                        state_q     <= StRun;
                        busy        <= 1'b1;
                        mode_all_q  <= mode_all;
                        sat_q       <= sat_en;
                        relu_q      <= relu_en;
                        row_q       <= mode_all ? '0 : row_select;
                        base_q      <= start_base;
                        weight_addr <= start_base;
                        pixel_addr  <= '0;
                        pixel_rd    <= 1'b1;
                        weight_rd   <= 1'b1;
                        acc_q       <= '0;
                        ovf_q       <= 1'b0;
                    end
                end
                StRun: begin
                    if (pixel_addr == LAST_WORD) begin
                        state_q     <= StDrain;
                        pixel_addr  <= '0;
                        weight_addr <= '0;
                        pixel_rd    <= 1'b0;
                        weight_rd   <= 1'b0;
                    end else begin
                        pixel_addr  <= pixel_addr + PADDR_W'(1);
                        weight_addr <= weight_addr + WADDR_W'(1);
                    end
                end
                StDrain: begin
                    // The last product is being accumulated on this edge.
                    if (prod_valid_q && !data_valid_q) begin
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    row_done     <= 1'b1;
                    w_result_ena <= 1'b1;
                    row_result   <= relu_val;
                    row_index    <= row_q;
                    overflow     <= ovf_q;
                    acc_q        <= '0;
                    ovf_q        <= 1'b0;
                    if (mode_all_q && row_q != LAST_ROW) begin
                        state_q     <= StRun;
                        row_q       <= row_q + ROW_W'(1);
                        base_q      <= base_q + ROW_STRIDE;
                        weight_addr <= base_q + ROW_STRIDE;
                        pixel_addr  <= '0;
                        pixel_rd    <= 1'b1;
                        weight_rd   <= 1'b1;
                    end else begin
                        state_q  <= StIdle;
                        busy     <= 1'b0;
                        all_done <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
